posit_cmd_scheduler: RTL and testbench

Command scheduler between the MMIO command decoder and the posit locality functional unit. It buffers posit instruction words written over MMIO and issues them to the FU under valid/ready flow control. It caps the number of in-flight instructions and provides run, drain and stop sequencing. It exposes status and counters for the MMIO read path, so software can post bursts of commands without polling the FU's ready.

---
 rtl/posit_cmd_scheduler_if.sv | 26 ++
 rtl/posit_cmd_scheduler.sv | 157 +++++++++++++++
 tb/tb_posit_cmd_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_cmd_scheduler_if.sv
// Command-path bundle between MMIO decoder, scheduler and posit FU.
// slave = scheduler side, master = MMIO/FU environment side.
interface posit_cmd_scheduler_if #(
    parameter int CMD_W = 64
);
    logic             cmd_wr_valid;
    logic [CMD_W-1:0] cmd_wr_data;
    logic             ctrl_wr_valid;
    logic [2:0]       ctrl_wr_data;
    logic             fu_req_valid;
    logic [CMD_W-1:0] fu_req_data;
    logic             fu_req_ready;
    logic             fu_done_valid;

    modport master (
        output cmd_wr_valid, cmd_wr_data, ctrl_wr_valid, ctrl_wr_data,
        output fu_req_ready, fu_done_valid,
        input  fu_req_valid, fu_req_data
    );

    modport slave (
        input  cmd_wr_valid, cmd_wr_data, ctrl_wr_valid, ctrl_wr_data,
        input  fu_req_ready, fu_done_valid,
        output fu_req_valid, fu_req_data
    );
endinterface

// File: rtl/posit_cmd_scheduler.sv
// Buffers MMIO posit commands and issues them to the FU with an in-flight cap.
// Latency: write -> fu_req_valid two cycles; backpressure holds the output register stable.
module posit_cmd_scheduler #(
    parameter int CMD_W        = 64,
    parameter int DEPTH        = 16,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    posit_cmd_scheduler_if.slave   bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             inflight_count,
    output logic [1:0]             state,
    output logic                   idle,
    output logic                   overflow_err,
    output logic                   underflow_err,
    output logic [31:0]            issued_count,
    output logic [31:0]            retired_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_DRAIN   = 2'd2
    } st_e;

    st_e              st_q;
    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             out_valid;
    logic [CMD_W-1:0] out_data;

    logic             hs;
    logic             done;
    logic             fifo_full;
    logic             fifo_empty;
    logic             enq;
    logic             load;
    logic [7:0]       inflight_eff;
    logic [8:0]       cap_sum;
    logic [7:0]       inflight_nxt;
    logic             out_valid_nxt;
    logic [CNT_W-1:0] fifo_count_nxt;
    logic             go;
    logic             halt;
    logic             clr_err;
    logic             clr_cnt;
    logic             drain_done;
    logic             stop_nxt;
    logic             idle_nxt;

    assign hs         = out_valid & bus.fu_req_ready;
    assign done       = bus.fu_done_valid;
    assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign enq        = bus.cmd_wr_valid & ~fifo_full;

    assign go      = bus.ctrl_wr_valid &  bus.ctrl_wr_data[0];
    assign halt    = bus.ctrl_wr_valid & ~bus.ctrl_wr_data[0];
    assign clr_err = bus.ctrl_wr_valid &  bus.ctrl_wr_data[1];
    assign clr_cnt = bus.ctrl_wr_valid &  bus.ctrl_wr_data[2];

    // Headroom counts the output register as in flight; a retire this cycle frees a slot,
    // while a handshake only moves a command from the register into the FU.
    assign inflight_eff = (done && inflight_count != 8'd0) ? inflight_count - 8'd1 : inflight_count;
    assign cap_sum      = {1'b0, inflight_eff} + 9'(out_valid);

    assign load = (st_q == ST_RUN) & ~fifo_empty & (~out_valid | hs) &
                  (cap_sum < 9'(MAX_INFLIGHT));

    always_comb begin
        inflight_nxt = inflight_count;
        case ({hs, done})
            2'b10:   inflight_nxt = inflight_count + 8'd1;
            2'b01:   inflight_nxt = inflight_eff;
            default: inflight_nxt = inflight_count;
        endcase
    end

    assign out_valid_nxt  = load | (out_valid & ~hs);
    assign fifo_count_nxt = fifo_count + CNT_W'(enq) - CNT_W'(load);

    // Evaluated on next-cycle values so STOPPED shows the cycle after the last retire.
    assign drain_done = ~out_valid_nxt & (inflight_nxt == 8'd0);
    assign stop_nxt   = ((st_q == ST_STOPPED) & ~go) |
                        ((st_q == ST_DRAIN) & ~go & drain_done);
    assign idle_nxt   = stop_nxt & (fifo_count_nxt == '0) & ~out_valid_nxt &
                        (inflight_nxt == 8'd0);

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= bus.cmd_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            inflight_count <= 8'd0;
            overflow_err   <= 1'b0;
            underflow_err  <= 1'b0;
            issued_count   <= 32'd0;
            retired_count  <= 32'd0;
            idle           <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                out_data <= mem[rd_ptr];
            end
            fifo_count     <= fifo_count_nxt;
            out_valid      <= out_valid_nxt;
            inflight_count <= inflight_nxt;
            idle           <= idle_nxt;

            overflow_err  <= (bus.cmd_wr_valid & fifo_full) | (overflow_err & ~clr_err);
            underflow_err <= (done & (inflight_count == 8'd0)) | (underflow_err & ~clr_err);

            if (clr_cnt) begin
                issued_count  <= 32'd0;
                retired_count <= 32'd0;
            end else begin
                issued_count  <= issued_count + 32'(hs);
                retired_count <= retired_count + 32'(done);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q <= ST_STOPPED;
        end else begin
            case (st_q)
                ST_STOPPED: if (go) st_q <= ST_RUN;
                ST_RUN:     if (halt) st_q <= ST_DRAIN;
                ST_DRAIN: begin
                    if (go)              st_q <= ST_RUN;
                    else if (drain_done) st_q <= ST_STOPPED;
                end
                default:    st_q <= ST_STOPPED;
            endcase
        end
    end

    assign state            = st_q;
    assign bus.fu_req_valid = out_valid;
    assign bus.fu_req_data  = out_data;
endmodule

// File: tb/tb_posit_cmd_scheduler.sv
// Directed-vector bench for posit_cmd_scheduler (CMD_W=64, DEPTH=16, MAX_INFLIGHT=8).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_posit_cmd_scheduler;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  fifo_count;
    logic [7:0]  inflight_count;
    logic [1:0]  state;
    logic        idle;
    logic        overflow_err;
    logic        underflow_err;
    logic [31:0] issued_count;
    logic [31:0] retired_count;

    int vectors = 0;
    int miscompares = 0;

    posit_cmd_scheduler_if #(.CMD_W(64)) bus ();

    posit_cmd_scheduler #(.CMD_W(64), .DEPTH(16), .MAX_INFLIGHT(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus.slave),
        .fifo_count     (fifo_count),
        .inflight_count (inflight_count),
        .state          (state),
        .idle           (idle),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err),
        .issued_count   (issued_count),
        .retired_count  (retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_cmd(input logic [63:0] d);
        bus.cmd_wr_valid = 1'b1;
        bus.cmd_wr_data  = d;
        tick();
        bus.cmd_wr_valid = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [2:0] v);
        bus.ctrl_wr_valid = 1'b1;
        bus.ctrl_wr_data  = v;
        tick();
        bus.ctrl_wr_valid = 1'b0;
    endtask

    task automatic done_pulse();
        bus.fu_done_valid = 1'b1;
        tick();
        bus.fu_done_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] w;
        int k;
        logic pend;

        reset_n           = 1'b0;
        bus.cmd_wr_valid  = 1'b0;
        bus.cmd_wr_data   = '0;
        bus.ctrl_wr_valid = 1'b0;
        bus.ctrl_wr_data  = '0;
        bus.fu_req_ready  = 1'b0;
        bus.fu_done_valid = 1'b0;
        tick(2);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_fifo", 64'(fifo_count), 64'd0);
        chk("rst_valid", 64'(bus.fu_req_valid), 64'd0);
        chk("rst_idle", 64'(idle), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_after_rst", 64'(idle), 64'd1);

        // Basic issue
        wr_ctrl(3'b001);
        chk("basic_state_run", 64'(state), 64'd1);
        bus.fu_req_ready = 1'b1;
        wr_cmd(64'h0123_4567_89AB_CDEF);
        chk("basic_c1_fifo", 64'(fifo_count), 64'd1);
        chk("basic_c1_valid", 64'(bus.fu_req_valid), 64'd0);
        tick();
        chk("basic_c2_valid", 64'(bus.fu_req_valid), 64'd1);
        chk("basic_c2_data", bus.fu_req_data, 64'h0123_4567_89AB_CDEF);
        chk("basic_c2_fifo", 64'(fifo_count), 64'd0);
        tick();
        chk("basic_issued", 64'(issued_count), 64'd1);
        chk("basic_inflight", 64'(inflight_count), 64'd1);
        done_pulse();
        chk("basic_inflight0", 64'(inflight_count), 64'd0);
        chk("basic_retired", 64'(retired_count), 64'd1);

        // Overflow in STOPPED
        wr_ctrl(3'b100);
        chk("drain_state", 64'(state), 64'd2);
        tick();
        chk("stopped_state", 64'(state), 64'd0);
        chk("cnt_cleared", 64'(issued_count), 64'd0);
        for (int i = 0; i < 17; i++) wr_cmd(64'hA000_0000_0000_0000 + 64'(i));
        chk("ovf_fifo", 64'(fifo_count), 64'd16);
        chk("ovf_flag", 64'(overflow_err), 64'd1);
        chk("ovf_no_issue", 64'(bus.fu_req_valid), 64'd0);
        wr_ctrl(3'b001);
        k = 0;
        pend = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.fu_req_valid) begin
                w = 64'hA000_0000_0000_0000 + 64'(k);
                chk("ovf_order", bus.fu_req_data, w);
                k++;
            end
            bus.fu_done_valid = pend;
            pend = bus.fu_req_valid;
            tick();
        end
        bus.fu_done_valid = 1'b0;
        tick();
        chk("ovf_issue_n", 64'(k), 64'd16);
        chk("ovf_issued", 64'(issued_count), 64'd16);
        chk("ovf_retired", 64'(retired_count), 64'd16);
        chk("ovf_inflight", 64'(inflight_count), 64'd0);
        chk("ovf_no_udf", 64'(underflow_err), 64'd0);
        wr_ctrl(3'b011);
        chk("ovf_cleared", 64'(overflow_err), 64'd0);
        chk("ovf_still_run", 64'(state), 64'd1);

        // In-flight cap
        wr_ctrl(3'b101);
        for (int i = 0; i < 12; i++) wr_cmd(64'hC000_0000_0000_0000 + 64'(i));
        tick(20);
        chk("cap_issued", 64'(issued_count), 64'd8);
        chk("cap_inflight", 64'(inflight_count), 64'd8);
        chk("cap_valid", 64'(bus.fu_req_valid), 64'd0);
        chk("cap_fifo", 64'(fifo_count), 64'd4);
        done_pulse();
        tick(5);
        chk("cap_one_more", 64'(issued_count), 64'd9);
        chk("cap_inflight2", 64'(inflight_count), 64'd8);
        chk("cap_fifo2", 64'(fifo_count), 64'd3);
        for (int i = 0; i < 11; i++) begin
            done_pulse();
            tick(3);
        end
        chk("cap_all_issued", 64'(issued_count), 64'd12);
        chk("cap_all_retired", 64'(retired_count), 64'd12);
        chk("cap_inflight0", 64'(inflight_count), 64'd0);

        // Backpressure stability
        bus.fu_req_ready = 1'b0;
        wr_cmd(64'hDEAD_BEEF_0000_0001);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.fu_req_valid), 64'd1);
            chk("bp_data", bus.fu_req_data, 64'hDEAD_BEEF_0000_0001);
            chk("bp_issued", 64'(issued_count), 64'd12);
            tick();
        end
        bus.fu_req_ready = 1'b1;
        tick();
        bus.fu_req_ready = 1'b0;
        chk("bp_one_hs", 64'(issued_count), 64'd13);
        chk("bp_valid_low", 64'(bus.fu_req_valid), 64'd0);
        done_pulse();
        chk("bp_retired", 64'(retired_count), 64'd13);

        // Drain
        bus.fu_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) wr_cmd(64'hE000_0000_0000_0000 + 64'(i));
        tick(4);
        chk("dr_inflight4", 64'(inflight_count), 64'd4);
        bus.fu_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr_cmd(64'hF000_0000_0000_0000 + 64'(i));
        tick(3);
        chk("dr_held_valid", 64'(bus.fu_req_valid), 64'd1);
        chk("dr_held_data", bus.fu_req_data, 64'hF000_0000_0000_0000);
        chk("dr_fifo2", 64'(fifo_count), 64'd2);
        wr_ctrl(3'b000);
        chk("dr_state", 64'(state), 64'd2);
        bus.fu_req_ready = 1'b1;
        tick();
        bus.fu_req_ready = 1'b0;
        chk("dr_issued", 64'(issued_count), 64'd18);
        chk("dr_inflight5", 64'(inflight_count), 64'd5);
        chk("dr_fifo_stays", 64'(fifo_count), 64'd2);
        chk("dr_no_load", 64'(bus.fu_req_valid), 64'd0);
        for (int i = 0; i < 4; i++) done_pulse();
        chk("dr_still_drain", 64'(state), 64'd2);
        done_pulse();
        chk("dr_stopped", 64'(state), 64'd0);
        chk("dr_not_idle", 64'(idle), 64'd0);
        chk("dr_retired", 64'(retired_count), 64'd18);
        bus.fu_req_ready = 1'b1;
        wr_ctrl(3'b001);
        tick(4);
        chk("dr_resume_issued", 64'(issued_count), 64'd20);
        chk("dr_resume_fifo", 64'(fifo_count), 64'd0);
        done_pulse();
        done_pulse();
        chk("dr_inflight0", 64'(inflight_count), 64'd0);

        // Underflow
        done_pulse();
        chk("udf_flag", 64'(underflow_err), 64'd1);
        chk("udf_inflight", 64'(inflight_count), 64'd0);
        chk("udf_retired", 64'(retired_count), 64'd21);
        wr_ctrl(3'b011);
        chk("udf_cleared", 64'(underflow_err), 64'd0);

        // Handshake and retire in the same cycle
        wr_cmd(64'h1111_2222_3333_4444);
        tick(3);
        chk("sim_pre_inflight", 64'(inflight_count), 64'd1);
        bus.fu_req_ready = 1'b0;
        wr_cmd(64'h5555_6666_7777_8888);
        tick();
        chk("sim_pre_valid", 64'(bus.fu_req_valid), 64'd1);
        bus.fu_req_ready  = 1'b1;
        bus.fu_done_valid = 1'b1;
        tick();
        bus.fu_req_ready  = 1'b0;
        bus.fu_done_valid = 1'b0;
        chk("sim_inflight", 64'(inflight_count), 64'd1);
        chk("sim_issued", 64'(issued_count), 64'd22);
        chk("sim_retired", 64'(retired_count), 64'd22);
        chk("sim_no_udf", 64'(underflow_err), 64'd0);

        // Reset mid-burst
        for (int i = 0; i < 3; i++) wr_cmd(64'h9000_0000_0000_0000 + 64'(i));
        tick(2);
        chk("pre_rst_valid", 64'(bus.fu_req_valid), 64'd1);
        reset_n = 1'b0;
        tick();
        chk("mrst_state", 64'(state), 64'd0);
        chk("mrst_fifo", 64'(fifo_count), 64'd0);
        chk("mrst_valid", 64'(bus.fu_req_valid), 64'd0);
        chk("mrst_data", bus.fu_req_data, 64'd0);
        chk("mrst_inflight", 64'(inflight_count), 64'd0);
        chk("mrst_issued", 64'(issued_count), 64'd0);
        chk("mrst_retired", 64'(retired_count), 64'd0);
        chk("mrst_idle", 64'(idle), 64'd0);
        chk("mrst_ovf", 64'(overflow_err), 64'd0);
        chk("mrst_udf", 64'(underflow_err), 64'd0);
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
